// File: rtl/signal_select_pp.sv
// signal_select_pp
//   Serial-to-parallel reorder buffer for the radix-4 FFT front end.
//   Serial samples fill one bank of a ping-pong pair. Once a bank holds a full
//   frame, it is presented as GROUPS parallel words of LANES samples each.
//   Lane j of group g carries frame sample j*GROUPS+g, which is
//   decimation-in-frequency order. The other bank keeps accepting input while
//   this happens.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   in_valid/in_ready     serial input handshake; data_in is a signed sample
//   out_valid/out_ready   parallel output handshake
//   data_out              lane j at bits [j*DATA_W +: DATA_W]; zero when idle
//   q_flag                group index of the current output word
//   out_last              high together with out_valid on the final group
//   in_sop, frame_err     only present when SIGNAL_SELECT_SOP_EN is defined:
//                         in_sop restarts framing mid-frame, and frame_err
//                         pulses for one cycle when that happens
//
// Build option
//   SIGNAL_SELECT_SOP_EN  enables start-of-packet resynchronisation

module signal_select_pp #(
    parameter int DATA_W = 32,
    parameter int N_PTS  = 16,
    parameter int LANES  = 4,
    localparam int GROUPS = N_PTS / LANES,
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int CW     = $clog2(N_PTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [GW-1:0]           q_flag,
    output logic                    out_last
`ifdef SIGNAL_SELECT_SOP_EN
    ,
    input  logic                    in_sop,
    output logic                    frame_err
`endif
);

    logic [DATA_W-1:0] bank_q [2][N_PTS];

    logic [1:0]    full_q,   full_d;
    logic          wr_sel_q, wr_sel_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          rd_sel_q, rd_sel_d;
    logic [GW-1:0] rd_grp_q, rd_grp_d;

    logic          accept;
    logic          xfer;
    logic          wr_en;
    logic [CW-1:0] wr_idx;

`ifdef SIGNAL_SELECT_SOP_EN
    logic frame_err_q, frame_err_d;
    assign frame_err = frame_err_q;
`endif

    always_comb begin
        in_ready  = !full_q[wr_sel_q];
        out_valid = full_q[rd_sel_q];
        out_last  = out_valid && (rd_grp_q == GW'(GROUPS - 1));
        q_flag    = rd_grp_q;
        accept    = in_valid && in_ready;
        xfer      = out_valid && out_ready;
    end

    // Write and read sides touch different banks: full[x] is only set while
    // it is clear (the write side), and only cleared while it is set (the
    // read side). That is why a single full_d can carry both updates.
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        wr_cnt_d = wr_cnt_q;
        rd_sel_d = rd_sel_q;
        rd_grp_d = rd_grp_q;
        wr_en    = accept && !reset;
        wr_idx   = wr_cnt_q;
`ifdef SIGNAL_SELECT_SOP_EN
        frame_err_d = 1'b0;
`endif

        if (accept) begin
`ifdef SIGNAL_SELECT_SOP_EN
            if (in_sop && (wr_cnt_q != '0)) begin
                // Resync: drop the partial frame and restart at index 0.
                wr_idx      = '0;
                wr_cnt_d    = CW'(1);
                frame_err_d = 1'b1;
            end else
`endif
            if (wr_cnt_q == CW'(N_PTS - 1)) begin
                wr_cnt_d         = '0;
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
            end else begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end

        if (xfer) begin
            if (rd_grp_q == GW'(GROUPS - 1)) begin
                rd_grp_d         = '0;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
            end else begin
                rd_grp_d = rd_grp_q + GW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_sel_q <= 1'b0;
            rd_grp_q <= '0;
`ifdef SIGNAL_SELECT_SOP_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            wr_cnt_q <= wr_cnt_d;
            rd_sel_q <= rd_sel_d;
            rd_grp_q <= rd_grp_d;
`ifdef SIGNAL_SELECT_SOP_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    // Sample storage is never cleared. A bank's contents are only visible
    // while its full flag is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[wr_sel_q][wr_idx] <= data_in;
        end
    end

    always_comb begin
        data_out = '0;
        if (out_valid) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                data_out[j*DATA_W +: DATA_W] =
                    bank_q[rd_sel_q][CW'(j * GROUPS) + CW'(rd_grp_q)];
            end
        end
    end

endmodule

// File: tb/tb_signal_select_pp.sv
module tb_signal_select_pp;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int L  = 4;
    localparam int G  = N / L;
    localparam int DW = L * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] data_out;
    logic [1:0]    q_flag;
    logic          out_last;
`ifdef SIGNAL_SELECT_SOP_EN
    logic in_sop = 1'b0;
    logic sop_next = 1'b0;
    logic pin_err = 1'b0;
    logic frame_err;
`endif

    always #5 clk = ~clk;

    signal_select_pp #(.DATA_W(W), .N_PTS(N), .LANES(L)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out),
        .q_flag(q_flag),
        .out_last(out_last)
`ifdef SIGNAL_SELECT_SOP_EN
        ,
        .in_sop(in_sop),
        .frame_err(frame_err)
`endif
    );

    // Reference model: completed frames wait in a queue (at most two can be
    // held), and the head frame is emitted group by group.
    logic [W-1:0]   wbuf [N];
    int             wcnt = 0;
    int             rgrp = 0;
    logic [N*W-1:0] frames [$];
    bit             chk_en = 1'b0;
    logic           ferr_exp = 1'b0;

    int total = 0;
    int bad = 0;
    int tmo_events = 0;
    int tmo_seen = 0;

    bit            pin_en = 1'b0;
    logic          pin_valid, pin_ready, pin_last;
    logic [1:0]    pin_q;
    logic [DW-1:0] pin_data;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [N*W-1:0] hd;
        logic [DW-1:0]  exp_d;
        logic           acc, xfr, ferr_nx;

        if (tmo_events != tmo_seen) begin
            chk("send_timeout", DW'(tmo_events), DW'(tmo_seen));
            tmo_seen = tmo_events;
        end

        if (chk_en) begin
            exp_d = '0;
            if (frames.size() > 0) begin
                hd = frames[0];
                for (int j = 0; j < L; j++) exp_d[j*W +: W] = hd[(j*G + rgrp)*W +: W];
            end
            chk("in_ready",  DW'(in_ready),  DW'(frames.size() < 2));
            chk("out_valid", DW'(out_valid), DW'(frames.size() > 0));
            chk("data_out",  data_out,       exp_d);
            chk("q_flag",    DW'(q_flag),    DW'(rgrp));
            chk("out_last",  DW'(out_last),  DW'(frames.size() > 0 && rgrp == G - 1));
`ifdef SIGNAL_SELECT_SOP_EN
            chk("frame_err", DW'(frame_err), DW'(ferr_exp));
`endif
            if (pin_en) begin
                chk("pin_valid", DW'(out_valid), DW'(pin_valid));
                chk("pin_ready", DW'(in_ready),  DW'(pin_ready));
                chk("pin_q",     DW'(q_flag),    DW'(pin_q));
                chk("pin_last",  DW'(out_last),  DW'(pin_last));
                chk("pin_data",  data_out,       pin_data);
`ifdef SIGNAL_SELECT_SOP_EN
                chk("pin_err",   DW'(frame_err), DW'(pin_err));
`endif
            end
        end

        if (reset) begin
            frames.delete();
            wcnt     = 0;
            rgrp     = 0;
            ferr_exp = 1'b0;
            chk_en   = 1'b1;
        end else if (chk_en) begin
            acc     = in_valid && (frames.size() < 2);
            xfr     = (frames.size() > 0) && out_ready;
            ferr_nx = 1'b0;
            if (xfr) begin
                if (rgrp == G - 1) begin
                    void'(frames.pop_front());
                    rgrp = 0;
                end else begin
                    rgrp++;
                end
            end
            if (acc) begin
`ifdef SIGNAL_SELECT_SOP_EN
                if (in_sop && wcnt != 0) begin
                    wcnt    = 0;
                    ferr_nx = 1'b1;
                end
`endif
                wbuf[wcnt] = data_in;
                wcnt++;
                if (wcnt == N) begin
                    hd = '0;
                    for (int k = 0; k < N; k++) hd[k*W +: W] = wbuf[k];
                    frames.push_back(hd);
                    wcnt = 0;
                end
            end
            ferr_exp = ferr_nx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] v);
        int  n;
        bit  ok;
        in_valid = 1'b1;
        data_in  = v;
`ifdef SIGNAL_SELECT_SOP_EN
        in_sop = sop_next;
`endif
        n  = 0;
        ok = 1'b0;
        while (!ok && n <= 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (ok) @(posedge clk);
        else tmo_events++;
        #1;
        in_valid = 1'b0;
`ifdef SIGNAL_SELECT_SOP_EN
        in_sop = 1'b0;
`endif
    endtask

    task automatic pin(input logic v, input logic r, input logic [1:0] q,
                       input logic last, input logic [DW-1:0] d);
        pin_valid = v;
        pin_ready = r;
        pin_q     = q;
        pin_last  = last;
        pin_data  = d;
        pin_en    = 1'b1;
        tick();
        pin_en = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        pin(1'b0, 1'b1, 2'd0, 1'b0, '0);

        // Frame 0..15 with the output always ready.
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send(W'(i));
        pin(1'b1, 1'b1, 2'd0, 1'b0, {32'd12, 32'd8,  32'd4, 32'd0});
        pin(1'b1, 1'b1, 2'd1, 1'b0, {32'd13, 32'd9,  32'd5, 32'd1});
        pin(1'b1, 1'b1, 2'd2, 1'b0, {32'd14, 32'd10, 32'd6, 32'd2});
        pin(1'b1, 1'b1, 2'd3, 1'b1, {32'd15, 32'd11, 32'd7, 32'd3});
        pin(1'b0, 1'b1, 2'd0, 1'b0, '0);

        // Three frames back-to-back.
        for (int i = 0; i < 3*N; i++) send(W'(1000 + i));
        repeat (8) tick();

        // Both banks fill while the output is stalled, then release.
        do_reset();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send(W'(100 + i));
            end
            begin
                repeat (38) tick();
                pin(1'b1, 1'b0, 2'd0, 1'b0, {32'd112, 32'd108, 32'd104, 32'd100});
                out_ready = 1'b1;
            end
        join
        for (int i = 40; i < 48; i++) send(W'(100 + i));
        pin(1'b1, 1'b1, 2'd0, 1'b0, {32'd144, 32'd140, 32'd136, 32'd132});
        repeat (8) tick();

        // Stall with extreme values and a toggling consumer.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            v = W'(i);
            if (i == 0)  v = 32'h8000_0000;
            if (i == 1)  v = 32'h7fff_ffff;
            if (i == 15) v = 32'hffff_ffff;
            send(v);
        end
        pin(1'b1, 1'b1, 2'd0, 1'b0, {32'd12, 32'd8, 32'd4, 32'h8000_0000});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        pin(1'b1, 1'b1, 2'd1, 1'b0, {32'd13, 32'd9, 32'd5, 32'h7fff_ffff});
        pin(1'b1, 1'b1, 2'd1, 1'b0, {32'd13, 32'd9, 32'd5, 32'h7fff_ffff});
        for (int i = 0; i < 24; i++) begin
            out_ready = ((i / 2) % 2) == 1;
            tick();
        end
        out_ready = 1'b1;
        pin(1'b0, 1'b1, 2'd0, 1'b0, '0);

        // Reset in the middle of a frame.
        do_reset();
        for (int i = 0; i < 7; i++) send(W'(500 + i));
        do_reset();
        pin(1'b0, 1'b1, 2'd0, 1'b0, '0);
        for (int i = 0; i < N; i++) send(W'(200 + i));
        pin(1'b1, 1'b1, 2'd0, 1'b0, {32'd212, 32'd208, 32'd204, 32'd200});
        repeat (6) tick();

`ifdef SIGNAL_SELECT_SOP_EN
        // Start-of-packet mid-frame resynchronises.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sop_next = (i == 0);
            send(W'(300 + i));
        end
        sop_next = 1'b1;
        send(W'(305));
        sop_next = 1'b0;
        pin_err = 1'b1;
        pin(1'b0, 1'b1, 2'd0, 1'b0, '0);
        pin_err = 1'b0;
        pin(1'b0, 1'b1, 2'd0, 1'b0, '0);
        for (int i = 1; i < N; i++) send(W'(305 + i));
        pin(1'b1, 1'b1, 2'd0, 1'b0, {32'd317, 32'd313, 32'd309, 32'd305});
        repeat (6) tick();
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
